// File: rtl/gated_valid_pipe_pkg.sv
// Shared elaboration helpers for gated_valid_pipe: parameter legality and counter limits.
package gated_valid_pipe_pkg;

  function automatic bit params_ok(input int width, input int stages,
                                   input int gate_stage, input int cnt_w);
    return (width >= 1) && (stages >= 1) && (gate_stage >= 0) &&
           (gate_stage < stages) && (cnt_w >= 1);
  endfunction

  function automatic longint unsigned cnt_max(input int cnt_w);
    return (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
  endfunction

endpackage

// File: rtl/gated_valid_pipe_stage.sv
// One register level of gated_valid_pipe, with load logic and optional predicate gate.
module br_gate_buf (
  input  logic in,
  output logic out
);
  assign out = in;
endmodule

module gated_valid_pipe_stage #(
  parameter int WIDTH = 1,
  parameter bit GATED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid_i,
  input  logic             up_pred_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_adv_i,
  output logic             ld_o,
  output logic             valid_o,
  output logic             pred_o,
  output logic [WIDTH-1:0] data_o
);
  logic             v_q, p_q;
  logic [WIDTH-1:0] d_q, d_d;

  assign ld_o = !v_q | dn_adv_i;

  // Gate each bit through a dedicated cell so synthesis cannot fold it away.
  if (GATED) begin : g_gate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      br_gate_buf u_buf (.in(up_data_i[i] & up_pred_i), .out(d_d[i]));
    end
  end else begin : g_pass
    assign d_d = up_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      p_q <= 1'b0;
      d_q <= '0;
    end else if (ld_o) begin
      v_q <= up_valid_i;
      p_q <= up_pred_i;
      d_q <= d_d;
    end
  end

  assign valid_o = v_q;
  assign pred_o  = p_q;
  assign data_o  = d_q;
endmodule

// File: rtl/gated_valid_pipe.sv
// Stallable valid/ready register pipe with predicate gating and a non-zero-data invariant checker.
module gated_valid_pipe
  import gated_valid_pipe_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int STAGES     = 2,
  parameter int GATE_STAGE = 1,
  parameter int CNT_W      = 8,
  parameter bit ASSERT_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_pred,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pred,
  output logic [WIDTH-1:0] out_data,
  input  logic             err_clr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  if (!params_ok(WIDTH, STAGES, GATE_STAGE, CNT_W)) begin : g_bad_params
    $error("gated_valid_pipe: illegal parameters (STAGES>=1, 0<=GATE_STAGE<STAGES required)");
  end

  // Per-stage scalars instead of arrays keep the combinational ready chain free of self-loops.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_v, up_p, dn_adv, v_k, p_k, ld_k;
    logic [WIDTH-1:0] up_d, d_k;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_p = in_pred;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = g_stage[k-1].v_k;
      assign up_p = g_stage[k-1].p_k;
      assign up_d = g_stage[k-1].d_k;
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_adv = out_ready;
    end else begin : g_mid
      assign dn_adv = v_k & g_stage[k+1].ld_k;
    end

    gated_valid_pipe_stage #(
      .WIDTH(WIDTH),
      .GATED(k == GATE_STAGE)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid_i(up_v),
      .up_pred_i (up_p),
      .up_data_i (up_d),
      .dn_adv_i  (dn_adv),
      .ld_o      (ld_k),
      .valid_o   (v_k),
      .pred_o    (p_k),
      .data_o    (d_k)
    );
  end

  assign in_ready  = g_stage[0].ld_k;
  assign out_valid = g_stage[STAGES-1].v_k;
  assign out_pred  = g_stage[STAGES-1].p_k;
  assign out_data  = g_stage[STAGES-1].d_k;

  logic             viol;
  logic             err_pulse_q, err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign viol = in_valid & in_ready & in_pred & (in_data == '0);

  // Clear takes priority, then a coincident violation counts as the first of the new window.
  always_comb begin
    err_sticky_d = err_sticky_q | viol;
    err_count_d  = err_count_q;
    if (err_clr) begin
      err_sticky_d = viol;
      err_count_d  = viol ? CNT_W'(1) : '0;
    end else if (viol && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      err_pulse_q  <= viol;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

`ifndef SYNTHESIS
  if (ASSERT_EN) begin : g_chk
    a_pred_nonzero : assert property (@(posedge clk)
      disable iff (!rst_n || $isunknown(in_data))
      (in_valid && in_ready && in_pred) |-> (in_data != '0))
      else $error("gated_valid_pipe: predicated word accepted with zero data");
  end
`endif
endmodule

// File: tb/tb_gated_valid_pipe.sv
// Directed and randomized checks of gated_valid_pipe against a queue-based reference.
module tb_gated_valid_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Small config: WIDTH=4, STAGES=2, GATE_STAGE=1, CNT_W=2, drives deliberate violations.
  logic       a_in_valid = 1'b0, a_in_pred = 1'b0, a_out_ready = 1'b0, a_err_clr = 1'b0;
  logic [3:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid, a_out_pred, a_err_pulse, a_err_sticky;
  logic [3:0] a_out_data;
  logic [1:0] a_err_count;

  gated_valid_pipe #(
    .WIDTH(4), .STAGES(2), .GATE_STAGE(1), .CNT_W(2), .ASSERT_EN(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pred(a_in_pred), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pred(a_out_pred), .out_data(a_out_data),
    .err_clr(a_err_clr), .err_pulse(a_err_pulse), .err_sticky(a_err_sticky), .err_count(a_err_count)
  );

  // Large config for the random stall regression.
  logic        b_in_valid = 1'b0, b_in_pred = 1'b0, b_out_ready = 1'b0, b_err_clr = 1'b0;
  logic [15:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_pred, b_err_pulse, b_err_sticky;
  logic [15:0] b_out_data;
  logic [7:0]  b_err_count;

  gated_valid_pipe #(
    .WIDTH(16), .STAGES(4), .GATE_STAGE(2), .CNT_W(8), .ASSERT_EN(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pred(b_in_pred), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pred(b_out_pred), .out_data(b_out_data),
    .err_clr(b_err_clr), .err_pulse(b_err_pulse), .err_sticky(b_err_sticky), .err_count(b_err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, starve;
    logic [16:0] q[$];

    repeat (2) @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_pred", a_out_pred, 0);
    check("rst_err_count", a_err_count, 0);
    check("rst_err_sticky", a_err_sticky, 0);
    rst_n = 1'b1;
    next_cyc();

    // Back-to-back stream, two-cycle latency.
    a_out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      a_in_valid = (j < 4);
      a_in_pred  = 1'b1;
      a_in_data  = 4'(j + 1);
      @(negedge clk);
      if (j < 4) check("s1_in_ready", a_in_ready, 1);
      check("s1_out_valid", a_out_valid, (j >= 2 && j <= 5));
      if (j >= 2 && j <= 5) check("s1_out_data", a_out_data, j - 1);
      next_cyc();
    end
    a_in_valid = 1'b0;
    check("s1_err_count", a_err_count, 0);

    // Gating at stage 1: stage 0 keeps the raw word, output sees zero.
    a_in_valid = 1'b1; a_in_pred = 1'b0; a_in_data = 4'd5;
    @(negedge clk);
    next_cyc();
    a_in_valid = 1'b0;
    @(negedge clk);
    check("s2_stage0_raw", dut_a.g_stage[0].u_stage.d_q, 5);
    check("s2_out_valid_early", a_out_valid, 0);
    next_cyc();
    @(negedge clk);
    check("s2_out_valid", a_out_valid, 1);
    check("s2_out_data", a_out_data, 0);
    check("s2_out_pred", a_out_pred, 0);
    next_cyc();

    // Stall for 5 cycles while offering 3 words.
    a_out_ready = 1'b0;
    sent = 0;
    for (int j = 0; j < 5; j++) begin
      a_in_valid = (sent < 3); a_in_pred = 1'b1; a_in_data = 4'(6 + sent);
      @(negedge clk);
      if (a_out_valid) check("s3_hold", a_out_data, 6);
      if (a_in_valid && a_in_ready) sent++;
      next_cyc();
    end
    check("s3_accepted", sent, 2);
    check("s3_in_ready_low", a_in_ready, 0);
    a_out_ready = 1'b1;
    got = 0;
    for (int j = 0; j < 20 && got < 3; j++) begin
      a_in_valid = (sent < 3); a_in_pred = 1'b1; a_in_data = 4'(6 + sent);
      @(negedge clk);
      if (a_out_valid) begin
        check("s3_order", a_out_data, 6 + got);
        got++;
      end
      if (a_in_valid && a_in_ready) sent++;
      next_cyc();
    end
    check("s3_received", got, 3);
    a_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("s3_no_dup", a_out_valid, 0);
      next_cyc();
    end

    // Three separated violations.
    for (int j = 0; j < 8; j++) begin
      a_in_valid = (j % 2 == 0) && (j < 6); a_in_pred = 1'b1; a_in_data = 4'd0;
      @(negedge clk);
      check("s4_pulse", a_err_pulse, (j % 2 == 1) && (j <= 5));
      next_cyc();
    end
    a_in_valid = 1'b0;
    check("s4_count", a_err_count, 3);
    check("s4_sticky", a_err_sticky, 1);
    a_err_clr = 1'b1;
    @(negedge clk);
    next_cyc();
    a_err_clr = 1'b0;
    @(negedge clk);
    check("s4_clr_count", a_err_count, 0);
    check("s4_clr_sticky", a_err_sticky, 0);
    next_cyc();

    // Saturation at 3 with CNT_W=2, then clear coincident with a violation.
    for (int j = 0; j < 5; j++) begin
      a_in_valid = 1'b1; a_in_pred = 1'b1; a_in_data = 4'd0;
      @(negedge clk);
      next_cyc();
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("s5_saturate", a_err_count, 3);
    next_cyc();
    a_in_valid = 1'b1; a_err_clr = 1'b1;
    @(negedge clk);
    next_cyc();
    a_in_valid = 1'b0; a_err_clr = 1'b0;
    @(negedge clk);
    check("s5_clr_viol_count", a_err_count, 1);
    check("s5_clr_viol_sticky", a_err_sticky, 1);
    next_cyc();
    repeat (3) next_cyc();

    // Asynchronous reset with two words in flight.
    a_in_valid = 1'b1; a_in_pred = 1'b1; a_in_data = 4'd9;
    next_cyc();
    a_in_data = 4'd10;
    next_cyc();
    a_in_valid = 1'b0;
    check("s6_pre_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_valid", a_out_valid, 0);
    check("s6_async_data", a_out_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("s6_no_stale", a_out_valid, 0);
      next_cyc();
    end
    check("s6_err_count", a_err_count, 0);

    // Random stall regression on the 4-stage, 16-bit instance.
    starve = 0;
    for (int cyc = 0; cyc < 2030; cyc++) begin
      b_in_valid  = (cyc < 2000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      b_out_ready = (cyc < 2000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_in_pred   = 1'($urandom_range(0, 1));
      b_in_data   = 16'($urandom);
      if (b_in_pred && b_in_data == 16'h0) b_in_data = 16'h1;
      @(negedge clk);
      check("b_in_ready", b_in_ready, (q.size() < 4) || b_out_ready);
      if (b_out_valid) begin
        if (q.size() == 0) check("b_sb_empty", b_out_valid, 0);
        else begin
          check("b_word", {b_out_pred, b_out_data}, q[0]);
          if (b_out_ready) void'(q.pop_front());
        end
      end
      if (q.size() > 0 && !b_out_valid) starve++;
      else starve = 0;
      if (starve >= 4) check("b_latency", b_out_valid, 1);
      if (b_in_valid && b_in_ready)
        q.push_back({b_in_pred, b_in_pred ? b_in_data : 16'h0});
      next_cyc();
    end
    check("b_drained", q.size(), 0);
    check("b_err_count", b_err_count, 0);
    check("b_err_sticky", b_err_sticky, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
